// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared encodings and idle level for the push-button conditioning path
package button_pkg;

  typedef enum logic [1:0] {
    HIGH    = 2'b00,
    TO_LOW  = 2'b01,
    LOW     = 2'b10,
    TO_HIGH = 2'b11
  } deb_state_e;

  // Released button reads high; also the reset value of every level-holding flop
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic state_level(input deb_state_e s);
    return (s == HIGH) || (s == TO_LOW);
  endfunction

  function automatic logic state_busy(input deb_state_e s);
    return (s == TO_LOW) || (s == TO_HIGH);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// rtl/key_debouncer_if.sv - raw key pin in, debounced level and qualification flag out
interface key_debouncer_if;

  logic KEY_n;
  logic a;
  logic busy;

  modport master (
    output KEY_n,
    input  a,
    input  busy
  );

  modport slave (
    input  KEY_n,
    output a,
    output busy
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for an asynchronous level, idles high
module sync2
  import button_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1 <= IDLE_LEVEL;
      q  <= IDLE_LEVEL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - counter-qualified debouncer producing a glitch-free idle-high key level
module key_debouncer
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 19
) (
  input  logic           Clock,
  input  logic           Reset,
  key_debouncer_if.slave key
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  deb_state_e       state;
  deb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  sync2 u_sync2 (
    .Clock (Clock),
    .Reset (Reset),
    .d     (key.KEY_n),
    .q     (s2)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= HIGH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A contrary sample is checked before the terminal count so it always aborts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      HIGH: begin
        if (!s2) begin
          state_nxt = TO_LOW;
          cnt_nxt   = '0;
        end
      end
      TO_LOW: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOW: begin
        if (s2) begin
          state_nxt = TO_HIGH;
          cnt_nxt   = '0;
        end
      end
      TO_HIGH: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = HIGH;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the state register only, so they cannot glitch
  assign key.a    = state_level(state);
  assign key.busy = state_busy(state);

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed self-checking bench for key_debouncer
module tb_key_debouncer;

  logic Clock;
  logic Reset;
  int   n_pass;
  int   n_total;

  // downstream falling-edge pulse stage, as the conditioning block would see it
  logic a_q;
  logic a_pulse;

  key_debouncer_if kif ();

  key_debouncer #(
    .STABLE_CYCLES (4),
    .CNT_W         (19)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .key   (kif)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q     <= 1'b1;
      a_pulse <= 1'b0;
    end else begin
      a_q     <= kif.a;
      a_pulse <= a_q & ~kif.a;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    kif.KEY_n = 1'b1;
    tick();
    tick();
    n_total++;
    if (kif.a !== 1'b1) $display("FAIL reset_a got=%b exp=1", kif.a);
    else n_pass++;
    n_total++;
    if (kif.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", kif.busy);
    else n_pass++;
    n_total++;
    if (dut.cnt !== 19'd0) $display("FAIL reset_cnt got=%0d exp=0", dut.cnt);
    else n_pass++;
    Reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_clean_press();
    logic exp_a, exp_busy;
    kif.KEY_n = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      exp_a    = (i < 6);
      exp_busy = (i >= 2) && (i <= 5);
      n_total++;
      if (kif.a !== exp_a) $display("FAIL press_a edge=k+%0d got=%b exp=%b", i, kif.a, exp_a);
      else n_pass++;
      n_total++;
      if (kif.busy !== exp_busy) $display("FAIL press_busy edge=k+%0d got=%b exp=%b", i, kif.busy, exp_busy);
      else n_pass++;
    end
    repeat (3) tick();
  endtask

  task automatic test_release_bounce();
    logic [10:0] seq;
    logic        exp_a;
    seq = 11'b111_1111_0101;
    for (int i = 0; i <= 10; i++) begin
      kif.KEY_n = seq[i];
      tick();
      exp_a = (i >= 10);
      n_total++;
      if (kif.a !== exp_a) $display("FAIL release_bounce_a edge=e%0d got=%b exp=%b", i, kif.a, exp_a);
      else n_pass++;
    end
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    logic [8:0] seq;
    logic       exp_busy;
    seq = 9'b1_1111_1000;
    for (int i = 0; i <= 8; i++) begin
      kif.KEY_n = seq[i];
      tick();
      exp_busy = (i >= 2) && (i <= 4);
      n_total++;
      if (kif.a !== 1'b1) $display("FAIL glitch_a edge=k+%0d got=%b exp=1", i, kif.a);
      else n_pass++;
      n_total++;
      if (kif.busy !== exp_busy) $display("FAIL glitch_busy edge=k+%0d got=%b exp=%b", i, kif.busy, exp_busy);
      else n_pass++;
    end
    n_total++;
    if (dut.cnt !== 19'd0) $display("FAIL glitch_cnt got=%0d exp=0", dut.cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_qual();
    logic exp_a;
    kif.KEY_n = 1'b0;
    for (int i = 0; i <= 4; i++) tick();
    n_total++;
    if (dut.cnt !== 19'd2) $display("FAIL midq_cnt_before got=%0d exp=2", dut.cnt);
    else n_pass++;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_total++;
    if (kif.a !== 1'b1) $display("FAIL midq_a got=%b exp=1", kif.a);
    else n_pass++;
    n_total++;
    if (kif.busy !== 1'b0) $display("FAIL midq_busy got=%b exp=0", kif.busy);
    else n_pass++;
    n_total++;
    if (dut.cnt !== 19'd0) $display("FAIL midq_cnt got=%0d exp=0", dut.cnt);
    else n_pass++;
    for (int j = 0; j <= 6; j++) begin
      tick();
      exp_a = (j < 6);
      n_total++;
      if (kif.a !== exp_a) $display("FAIL midq_relatch_a edge=%0d got=%b exp=%b", j, kif.a, exp_a);
      else n_pass++;
    end
  endtask

  task automatic test_reset_held();
    logic exp_a;
    kif.KEY_n = 1'b1;
    repeat (10) tick();
    kif.KEY_n = 1'b0;
    Reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (kif.a !== 1'b1) $display("FAIL held_reset_a cycle=%0d got=%b exp=1", i, kif.a);
      else n_pass++;
    end
    Reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      exp_a = (j < 7);
      n_total++;
      if (kif.a !== exp_a) $display("FAIL held_after_reset_a edge=%0d got=%b exp=%b", j, kif.a, exp_a);
      else n_pass++;
    end
    kif.KEY_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_chained();
    logic [49:0] seq;
    logic        prev_a;
    int          n_falls, n_pulse, fall_idx, pulse_idx;
    seq = '1;
    seq[4:0] = 5'b01010;
    for (int i = 5; i < 25; i++) seq[i] = 1'b0;
    seq[29:25] = 5'b10101;
    n_falls   = 0;
    n_pulse   = 0;
    fall_idx  = -1;
    pulse_idx = -1;
    prev_a    = kif.a;
    for (int i = 0; i < 50; i++) begin
      kif.KEY_n = seq[i];
      tick();
      if (prev_a && !kif.a) begin
        n_falls++;
        fall_idx = i;
      end
      if (a_pulse) begin
        n_pulse++;
        if (pulse_idx < 0) pulse_idx = i;
      end
      prev_a = kif.a;
    end
    n_total++;
    if (n_falls !== 1) $display("FAIL chain_falls got=%0d exp=1", n_falls);
    else n_pass++;
    n_total++;
    if (n_pulse !== 1) $display("FAIL chain_pulse_cycles got=%0d exp=1", n_pulse);
    else n_pass++;
    n_total++;
    if (pulse_idx !== fall_idx + 1) $display("FAIL chain_pulse_delay got=%0d exp=%0d", pulse_idx, fall_idx + 1);
    else n_pass++;
    n_total++;
    if (kif.a !== 1'b1) $display("FAIL chain_final_a got=%b exp=1", kif.a);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    Reset     = 1'b1;
    kif.KEY_n = 1'b1;
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_glitch();
    test_reset_mid_qual();
    test_reset_held();
    test_chained();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
